// File: rtl/pc_sequencer.sv
// PC sequencing control: selects advance/stall/jump/return each cycle and runs interrupt entry/exit.
// Outputs are combinational from registered state so the PC register samples them on the same edge.
module pc_sequencer #(
  parameter logic [31:0] ISR_ADDR     = 32'h0000_0400,
  parameter int unsigned FLUSH_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        irq_req,
  input  logic        eret,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        hazard_lu,
  input  logic [31:0] pc,
  output logic        pc_en,
  output logic        pc_load_use,
  output logic        pc_int_nop,
  output logic        pc_jp_success,
  output logic        pc_irq_ret,
  output logic [31:0] pc_new,
  output logic [31:0] epc,
  output logic        in_isr,
  output logic        irq_ack
);

  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_DRAIN  = 3'd1,
    ST_VECTOR = 3'd2,
    ST_ISR    = 3'd3,
    ST_RETURN = 3'd4
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] epc_q, epc_d;
  logic        in_isr_q, in_isr_d;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    epc_d         = epc_q;
    in_isr_d      = in_isr_q;
    pc_en         = 1'b0;
    pc_load_use   = 1'b0;
    pc_int_nop    = 1'b0;
    pc_jp_success = 1'b0;
    pc_irq_ret    = 1'b0;
    irq_ack       = 1'b0;
    pc_new        = 32'h0;

    unique case (state_q)
      ST_RUN: begin
        if (branch_taken) begin
          pc_jp_success = 1'b1;
          pc_new        = branch_target;
        end else if (hazard_lu) begin
          pc_load_use = 1'b1;
        end else if (irq_req) begin
          // Recognition cycle counts as the first of the FLUSH_CYCLES+1 nop cycles.
          pc_int_nop = 1'b1;
          epc_d      = pc;
          cnt_d      = CNT_LOAD;
          state_d    = ST_DRAIN;
        end else begin
          pc_en = 1'b1;
        end
      end
      ST_DRAIN: begin
        pc_int_nop = 1'b1;
        if (cnt_q == 4'd0) begin
          state_d = ST_VECTOR;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_VECTOR: begin
        pc_jp_success = 1'b1;
        pc_new        = ISR_ADDR;
        irq_ack       = 1'b1;
        in_isr_d      = 1'b1;
        state_d       = ST_ISR;
      end
      ST_ISR: begin
        // No nesting: irq_req is not looked at here; a branch swallows a coincident eret.
        if (branch_taken) begin
          pc_jp_success = 1'b1;
          pc_new        = branch_target;
        end else if (hazard_lu) begin
          pc_load_use = 1'b1;
        end else begin
          pc_en = 1'b1;
          if (eret) begin
            state_d = ST_RETURN;
          end
        end
      end
      ST_RETURN: begin
        pc_irq_ret = 1'b1;
        pc_new     = epc_q;
        in_isr_d   = 1'b0;
        state_d    = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    if (rst) begin
      pc_en         = 1'b0;
      pc_load_use   = 1'b0;
      pc_int_nop    = 1'b0;
      pc_jp_success = 1'b0;
      pc_irq_ret    = 1'b0;
      irq_ack       = 1'b0;
      pc_new        = 32'h0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_RUN;
      cnt_q    <= 4'd0;
      epc_q    <= 32'h0;
      in_isr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      epc_q    <= epc_d;
      in_isr_q <= in_isr_d;
    end
  end

  assign epc    = epc_q;
  assign in_isr = in_isr_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: inputs driven on negedge, outputs sampled 1ns later.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        irq_req, eret, branch_taken, hazard_lu;
  logic [31:0] branch_target, pc;
  logic        pc_en, pc_load_use, pc_int_nop, pc_jp_success, pc_irq_ret, in_isr, irq_ack;
  logic [31:0] pc_new, epc;
  logic [5:0]  outs;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [5:0] O_NONE = 6'b000000;
  localparam logic [5:0] O_EN   = 6'b100000;
  localparam logic [5:0] O_LU   = 6'b010000;
  localparam logic [5:0] O_NOP  = 6'b001000;
  localparam logic [5:0] O_JP   = 6'b000100;
  localparam logic [5:0] O_RET  = 6'b000010;
  localparam logic [5:0] O_VEC  = 6'b000101;

  pc_sequencer #(.ISR_ADDR(32'h0000_0400), .FLUSH_CYCLES(3)) dut (
    .clk(clk), .rst(rst), .irq_req(irq_req), .eret(eret),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .hazard_lu(hazard_lu), .pc(pc),
    .pc_en(pc_en), .pc_load_use(pc_load_use), .pc_int_nop(pc_int_nop),
    .pc_jp_success(pc_jp_success), .pc_irq_ret(pc_irq_ret), .pc_new(pc_new),
    .epc(epc), .in_isr(in_isr), .irq_ack(irq_ack)
  );

  assign outs = {pc_en, pc_load_use, pc_int_nop, pc_jp_success, pc_irq_ret, irq_ack};

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst = 1'b1; irq_req = 1'b0; eret = 1'b0; hazard_lu = 1'b0;
    branch_taken = 1'b1; branch_target = 32'h55; pc = 32'h0;
    #1;
    n_tests++;
    if (outs !== O_NONE || pc_new !== 32'h0) begin
      n_fail++; $display("FAIL reset_outs: got outs=%b pc_new=%h, want 000000/0", outs, pc_new);
    end
    n_tests++;
    if (epc !== 32'h0 || in_isr !== 1'b0) begin
      n_fail++; $display("FAIL reset_regs: got epc=%h in_isr=%b, want 0/0", epc, in_isr);
    end
    @(negedge clk); rst = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
  endtask

  task automatic test_plain_run();
    pc = 32'h10;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      n_tests++;
      if (outs !== O_EN || pc_new !== 32'h0) begin
        n_fail++; $display("FAIL plain_run[%0d]: got outs=%b pc_new=%h, want 100000/0", i, outs, pc_new);
      end
    end
  endtask

  task automatic test_priority();
    @(negedge clk); branch_taken = 1'b1; branch_target = 32'h44; hazard_lu = 1'b1; #1;
    n_tests++;
    if (outs !== O_JP || pc_new !== 32'h44) begin
      n_fail++; $display("FAIL prio_branch: got outs=%b pc_new=%h, want 000100/44", outs, pc_new);
    end
    @(negedge clk); branch_taken = 1'b0; irq_req = 1'b1; #1;
    n_tests++;
    if (outs !== O_LU || pc_new !== 32'h0) begin
      n_fail++; $display("FAIL prio_hazard: got outs=%b pc_new=%h, want 010000/0", outs, pc_new);
    end
    @(negedge clk); hazard_lu = 1'b0; irq_req = 1'b0; eret = 1'b1; #1;
    n_tests++;
    if (outs !== O_EN) begin
      n_fail++; $display("FAIL eret_in_run: got outs=%b, want 100000", outs);
    end
    @(negedge clk); eret = 1'b0; #1;
    n_tests++;
    if (outs !== O_EN || in_isr !== 1'b0) begin
      n_fail++; $display("FAIL eret_in_run_next: got outs=%b in_isr=%b, want 100000/0", outs, in_isr);
    end
  endtask

  task automatic test_irq_entry();
    int nop_run = 0;
    @(negedge clk); irq_req = 1'b1; pc = 32'h20; #1;
    n_tests++;
    if (outs !== O_NOP) begin
      n_fail++; $display("FAIL irq_recognize: got outs=%b, want 001000", outs);
    end
    if (pc_int_nop === 1'b1) nop_run++;
    @(negedge clk); irq_req = 1'b0; #1;
    n_tests++;
    if (epc !== 32'h20) begin
      n_fail++; $display("FAIL irq_epc: got %h, want 00000020", epc);
    end
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      n_tests++;
      if (outs !== O_NOP) begin
        n_fail++; $display("FAIL irq_drain[%0d]: got outs=%b, want 001000", i, outs);
      end
      if (pc_int_nop === 1'b1) nop_run++;
    end
    @(negedge clk); #1;
    n_tests++;
    if (nop_run != 4) begin
      n_fail++; $display("FAIL nop_length: got %0d cycles, want 4", nop_run);
    end
    n_tests++;
    if (outs !== O_VEC || pc_new !== 32'h400 || in_isr !== 1'b0) begin
      n_fail++; $display("FAIL irq_vector: got outs=%b pc_new=%h in_isr=%b, want 000101/400/0", outs, pc_new, in_isr);
    end
    @(negedge clk); pc = 32'h400; #1;
    n_tests++;
    if (outs !== O_EN || in_isr !== 1'b1) begin
      n_fail++; $display("FAIL isr_enter: got outs=%b in_isr=%b, want 100000/1", outs, in_isr);
    end
  endtask

  task automatic test_return();
    @(negedge clk); eret = 1'b1; pc = 32'h404; #1;
    n_tests++;
    if (outs !== O_EN) begin
      n_fail++; $display("FAIL eret_cycle: got outs=%b, want 100000", outs);
    end
    @(negedge clk); eret = 1'b0; #1;
    n_tests++;
    if (outs !== O_RET || pc_new !== 32'h20 || in_isr !== 1'b1) begin
      n_fail++; $display("FAIL return: got outs=%b pc_new=%h in_isr=%b, want 000010/20/1", outs, pc_new, in_isr);
    end
    @(negedge clk); pc = 32'h20; #1;
    n_tests++;
    if (outs !== O_EN || in_isr !== 1'b0 || epc !== 32'h20) begin
      n_fail++; $display("FAIL after_return: got outs=%b in_isr=%b epc=%h, want 100000/0/20", outs, in_isr, epc);
    end
  endtask

  task automatic test_branch_irq_collision();
    @(negedge clk); branch_taken = 1'b1; branch_target = 32'h80; irq_req = 1'b1; pc = 32'h7c; #1;
    n_tests++;
    if (outs !== O_JP || pc_new !== 32'h80) begin
      n_fail++; $display("FAIL collide_branch: got outs=%b pc_new=%h, want 000100/80", outs, pc_new);
    end
    @(negedge clk); branch_taken = 1'b0; branch_target = 32'h0; pc = 32'h80; #1;
    n_tests++;
    if (outs !== O_NOP) begin
      n_fail++; $display("FAIL collide_recognize: got outs=%b, want 001000", outs);
    end
    @(negedge clk); #1;
    n_tests++;
    if (epc !== 32'h80) begin
      n_fail++; $display("FAIL collide_epc: got %h, want 00000080", epc);
    end
    // irq_req stays high from here through the whole ISR.
    @(negedge clk); @(negedge clk); @(negedge clk); #1;
    n_tests++;
    if (outs !== O_VEC || pc_new !== 32'h400) begin
      n_fail++; $display("FAIL collide_vector: got outs=%b pc_new=%h, want 000101/400", outs, pc_new);
    end
  endtask

  task automatic test_no_nesting();
    int acks = 0;
    pc = 32'h400;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      if (irq_ack === 1'b1) acks++;
      n_tests++;
      if (outs !== O_EN || in_isr !== 1'b1) begin
        n_fail++; $display("FAIL isr_irq_held[%0d]: got outs=%b in_isr=%b, want 100000/1", i, outs, in_isr);
      end
    end
    @(negedge clk); branch_taken = 1'b1; branch_target = 32'h480; eret = 1'b1; #1;
    if (irq_ack === 1'b1) acks++;
    n_tests++;
    if (outs !== O_JP || pc_new !== 32'h480) begin
      n_fail++; $display("FAIL isr_branch_eret: got outs=%b pc_new=%h, want 000100/480", outs, pc_new);
    end
    @(negedge clk); branch_taken = 1'b0; branch_target = 32'h0; eret = 1'b0; pc = 32'h480; #1;
    if (irq_ack === 1'b1) acks++;
    n_tests++;
    if (outs !== O_EN || in_isr !== 1'b1) begin
      n_fail++; $display("FAIL eret_dropped: got outs=%b in_isr=%b, want 100000/1", outs, in_isr);
    end
    @(negedge clk); eret = 1'b1; #1;
    if (irq_ack === 1'b1) acks++;
    @(negedge clk); eret = 1'b0; #1;
    if (irq_ack === 1'b1) acks++;
    n_tests++;
    if (outs !== O_RET || pc_new !== 32'h80) begin
      n_fail++; $display("FAIL nest_return: got outs=%b pc_new=%h, want 000010/80", outs, pc_new);
    end
    n_tests++;
    if (acks != 0) begin
      n_fail++; $display("FAIL nest_ack: got %0d acks during ISR, want 0", acks);
    end
    @(negedge clk); irq_req = 1'b0; pc = 32'h80; #1;
    n_tests++;
    if (outs !== O_EN || in_isr !== 1'b0) begin
      n_fail++; $display("FAIL nest_after: got outs=%b in_isr=%b, want 100000/0", outs, in_isr);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); irq_req = 1'b1; pc = 32'h30; #1;
    n_tests++;
    if (outs !== O_NOP) begin
      n_fail++; $display("FAIL mid_recognize: got outs=%b, want 001000", outs);
    end
    @(negedge clk); irq_req = 1'b0; #1;
    @(negedge clk); rst = 1'b1; #1;
    n_tests++;
    if (outs !== O_NONE || pc_new !== 32'h0 || epc !== 32'h0 || in_isr !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset: got outs=%b pc_new=%h epc=%h in_isr=%b, want 000000/0/0/0", outs, pc_new, epc, in_isr);
    end
    @(negedge clk); rst = 1'b0; #1;
    n_tests++;
    if (outs !== O_EN || in_isr !== 1'b0 || epc !== 32'h0) begin
      n_fail++; $display("FAIL mid_release: got outs=%b in_isr=%b epc=%h, want 100000/0/0", outs, in_isr, epc);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      n_tests++;
      if (outs !== O_EN) begin
        n_fail++; $display("FAIL mid_no_pending[%0d]: got outs=%b, want 100000", i, outs);
      end
    end
  endtask

  initial begin
    test_reset();
    test_plain_run();
    test_priority();
    test_irq_entry();
    test_return();
    test_branch_irq_collision();
    test_no_nesting();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
